// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: command opcodes, FSM states and
// small opcode-classification helpers.
package mem_access_unit_pkg;

    localparam logic [1:0] MAU_LD   = 2'd0;
    localparam logic [1:0] MAU_ST   = 2'd1;
    localparam logic [1:0] MAU_PUSH = 2'd2;
    localparam logic [1:0] MAU_POP  = 2'd3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StFin  = 2'd3
    } mau_state_e;

    function automatic logic op_is_write(input logic [1:0] op);
        return (op == MAU_ST) || (op == MAU_PUSH);
    endfunction

    function automatic logic op_is_stack(input logic [1:0] op);
        return (op == MAU_PUSH) || (op == MAU_POP);
    endfunction

endpackage

// File: rtl/mau_stack_ptr.sv
// Architectural stack pointer (full-descending). Exposes sp and sp-1 so PUSH can
// address the pre-decremented slot; moves by one on each update strobe.
module mau_stack_ptr #(
    parameter int unsigned       ADDR_W  = 16,
    parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              upd_i,
    input  logic              pop_i,
    output logic [ADDR_W-1:0] sp_o,
    output logic [ADDR_W-1:0] sp_dec_o
);

    logic [ADDR_W-1:0] sp_q, sp_d;

    always_comb begin
        sp_d = sp_q;
        if (upd_i) begin
            // Wraps modulo 2^ADDR_W in both directions, no flag
            sp_d = pop_i ? (sp_q + ADDR_W'(1)) : (sp_q - ADDR_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_q <= SP_INIT;
        end else begin
            sp_q <= sp_d;
        end
    end

    assign sp_o     = sp_q;
    assign sp_dec_o = sp_q - ADDR_W'(1);

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle LD/ST/PUSH/POP engine with a req/ack data-memory handshake.
// Optional wait-for-ack timeout enabled by defining MAU_TIMEOUT_EN.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 16,
    parameter logic [ADDR_W-1:0] SP_INIT = 16'hFFFF,
    parameter int unsigned       TMO_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [ADDR_W-1:0] sp,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    mau_state_e        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              req_active;
    logic              accept;
    logic              tmo_hit;
    logic              sp_upd;
    logic [ADDR_W-1:0] sp_cur;
    logic [ADDR_W-1:0] sp_dec;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^addr[31:ADDR_W];

    assign req_active = (state_q == StReq) || (state_q == StWait);
    // FIN already reports busy=0, so a new command may be taken there too
    assign accept     = start && ((state_q == StIdle) || (state_q == StFin));

    mau_stack_ptr #(
        .ADDR_W  (ADDR_W),
        .SP_INIT (SP_INIT)
    ) u_stack_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .upd_i    (sp_upd),
        .pop_i    (op_q == MAU_POP),
        .sp_o     (sp_cur),
        .sp_dec_o (sp_dec)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        sp_upd  = 1'b0;

        case (state_q)
            StIdle, StFin: begin
                state_d = StIdle;
                if (accept) begin
                    state_d = StReq;
                    op_d    = op;
                    wdata_d = wdata;
                    case (op)
                        MAU_PUSH: addr_d = sp_dec;
                        MAU_POP:  addr_d = sp_cur;
                        default:  addr_d = addr[ADDR_W-1:0];
                    endcase
                end
            end
            StReq, StWait: begin
                if (mem_ack) begin
                    state_d = StFin;
                    sp_upd  = op_is_stack(op_q);
                    if (!op_is_write(op_q)) begin
                        rdata_d = mem_rdata;
                    end
                end else if (tmo_hit) begin
                    state_d = StFin;
                end else begin
                    state_d = StWait;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= MAU_LD;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MAU_TIMEOUT_EN
    localparam int unsigned TmoW = ($clog2(TMO_CYC + 1) > 8) ? $clog2(TMO_CYC + 1) : 8;

    logic [TmoW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    // cnt_q counts completed request cycles, so mem_req is high for exactly TMO_CYC cycles
    assign tmo_hit = req_active && !mem_ack && (cnt_q == TmoW'(TMO_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (accept) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else if (req_active) begin
            cnt_d = cnt_q + TmoW'(1);
            if (tmo_hit) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = (state_q == StFin) && err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    assign busy      = req_active;
    assign done      = (state_q == StFin);
    assign rdata     = rdata_q;
    assign sp        = sp_cur;
    assign mem_req   = req_active;
    assign mem_we    = req_active && op_is_write(op_q);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes model expectations, a negedge
// monitor checks bus traffic and completions. Define MAU_TIMEOUT_EN to add the timeout case.
module tb_mem_access_unit;

    localparam int unsigned AW  = 16;
    localparam logic [15:0] SPI = 16'hFFFF;
    localparam int unsigned TMO = 8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic [15:0] sp;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    mem_access_unit #(
        .ADDR_W  (AW),
        .SP_INIT (SPI),
        .TMO_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .sp        (sp),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        we;
        logic [15:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [15:0] sp;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_sp;
    logic [31:0] m_rdata;
    logic [31:0] m_mem[logic [15:0]];
    logic [31:0] b_mem[logic [15:0]];

    function automatic logic [31:0] init_word(input logic [15:0] a);
        return {~a, a};
    endfunction

    function automatic logic [31:0] m_read(input logic [15:0] a);
        return m_mem.exists(a) ? m_mem[a] : init_word(a);
    endfunction

    task automatic model_issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] w,
                               input bit tmo);
        exp_t e;
        e.we  = (o == 2'd1) || (o == 2'd2);
        e.wd  = w;
        e.err = tmo;
        case (o)
            2'd2:    e.a = m_sp - 16'd1;
            2'd3:    e.a = m_sp;
            default: e.a = a[15:0];
        endcase
        if (!tmo) begin
            if (e.we) m_mem[e.a] = w;
            else      m_rdata = m_read(e.a);
            if (o == 2'd2) m_sp = m_sp - 16'd1;
            if (o == 2'd3) m_sp = m_sp + 16'd1;
        end
        e.rd = m_rdata;
        e.sp = m_sp;
        exp_q.push_back(e);
    endtask

    // ---------------- memory responder ----------------
    int fixed_wait = -1;
    bit hold_ack   = 1'b0;
    bit inject_ack = 1'b0;

    initial begin
        int  wait_left;
        bit  in_txn;
        in_txn    = 1'b0;
        wait_left = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (mem_req && !hold_ack) begin
                if (!in_txn) begin
                    in_txn    = 1'b1;
                    wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 5));
                end
                if (wait_left == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = b_mem.exists(mem_addr) ? b_mem[mem_addr] : init_word(mem_addr);
                    if (mem_we) b_mem[mem_addr] = mem_wdata;
                    in_txn = 1'b0;
                end else begin
                    wait_left--;
                end
            end else if (!mem_req) begin
                in_txn = 1'b0;
            end
            if (inject_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hBAD0_BAD0;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        int req_cycles;
        bit ack_prev;
        req_cycles = 0;
        ack_prev   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                req_cycles = 0;
                ack_prev   = 1'b0;
            end else begin
                if (mem_req) begin
                    req_cycles++;
                    if (exp_q.size() == 0) begin
                        chk("bus_spurious_req", mem_req, 1'b0);
                    end else begin
                        chk("bus_we", mem_we, exp_q[0].we);
                        chk("bus_addr", mem_addr, exp_q[0].a);
                        if (exp_q[0].we) chk("bus_wdata", mem_wdata, exp_q[0].wd);
                    end
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_done", done, 1'b0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("done_rdata", rdata, e.rd);
                        chk("done_sp", sp, e.sp);
                        chk("done_err", err, e.err);
                        chk("done_busy", busy, 1'b0);
                        chk("done_req_low", mem_req, 1'b0);
                        if (e.err) chk("tmo_req_cycles", req_cycles, TMO);
                        else       chk("done_after_ack", ack_prev, 1'b1);
                    end
                    req_cycles = 0;
                end
                ack_prev = mem_req && mem_ack;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_txn(input logic [1:0] o, input logic [31:0] a, input logic [31:0] w,
                           input bit tmo);
        bit got;
        got = 1'b0;
        model_issue(o, a, w, tmo);
        start = 1'b1;
        op    = o;
        addr  = a;
        wdata = w;
        for (int c = 0; c < 60 && !got; c++) begin
            @(posedge clk);
            #2;
            if (done) begin
                got = 1'b1;
            end else begin
                // junk commands while busy must be ignored
                start = ($urandom_range(0, 3) == 0);
                op    = 2'($urandom);
                addr  = $urandom;
                wdata = $urandom;
            end
        end
        start = 1'b0;
        chk("txn_completed", got, 1'b1);
    endtask

    task automatic gap();
        int g;
        g = $urandom_range(0, 2);
        for (int i = 0; i < g; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = '0;
        addr    = '0;
        wdata   = '0;
        m_sp    = SPI;
        m_rdata = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_sp", sp, SPI);
        @(posedge clk);
        #2;

        // PUSH/POP round trip, then POP wrapping sp from FFFF to 0
        run_txn(2'd2, 32'h0, 32'h0000_0011, 1'b0);
        run_txn(2'd3, 32'h0, 32'h0, 1'b0);
        run_txn(2'd3, 32'h0, 32'h0, 1'b0);
        gap();

        // ST with ack one cycle after mem_req rises
        fixed_wait = 1;
        run_txn(2'd1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        // LD with five wait cycles, upper address bits ignored
        b_mem[16'h0020] = 32'hCAFE_F00D;
        m_mem[16'h0020] = 32'hCAFE_F00D;
        fixed_wait = 5;
        run_txn(2'd0, 32'h1234_0020, 32'h0, 1'b0);
        fixed_wait = -1;
        gap();

        for (int i = 0; i < 150; i++) begin
            logic [1:0]  o;
            logic [31:0] a;
            o = 2'($urandom);
            a = $urandom & 32'hFFFF_003F;
            run_txn(o, a, $urandom, 1'b0);
            gap();
        end

        // Reset while waiting for ack, then a stray ack after reset
        hold_ack = 1'b1;
        e.we = 1'b0; e.a = 16'h0040; e.wd = '0; e.rd = '0; e.sp = m_sp; e.err = 1'b0;
        exp_q.push_back(e);
        start = 1'b1; op = 2'd0; addr = 32'h0000_0040;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #2;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        exp_q.delete();
        m_sp       = SPI;
        m_rdata    = '0;
        hold_ack   = 1'b0;
        inject_ack = 1'b1;
        @(posedge clk);
        #2 inject_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_done", done, 1'b0);
            chk("post_rst_req", mem_req, 1'b0);
            chk("post_rst_sp", sp, SPI);
            chk("post_rst_rdata", rdata, 32'h0);
        end
        @(posedge clk);
        #2;
        run_txn(2'd0, 32'h0000_0020, 32'h0, 1'b0);

`ifdef MAU_TIMEOUT_EN
        hold_ack = 1'b1;
        run_txn(2'd3, 32'h0, 32'h0, 1'b1);
        hold_ack = 1'b0;
        gap();
        run_txn(2'd2, 32'h0, 32'h0000_0077, 1'b0);
`endif

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multi-cycle load/store/stack engine for the 32-bit CPU; the memory-side counterpart of the ALU's LD/ST address computation.
- Takes an ALU-computed address and a store operand from the pipeline, runs a req/ack handshake with the data memory, and returns load data.
- Owns the architectural stack pointer for PUSH/POP.

Parameters:
- ADDR_W, 16, word-address width driven onto the memory bus (low ADDR_W bits of the ALU result).
- SP_INIT, 16'hFFFF, stack pointer value after reset.
- TMO_CYC, 255, wait-for-ack limit in cycles (used only with MAU_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle command strobe; accepted only when busy=0.
- op  in  2  0=LD, 1=ST, 2=PUSH, 3=POP.
- addr  in  32  ALU result (effective address for LD/ST).
- wdata  in  32  store operand (ST/PUSH).
- busy  out  1  command in flight.
- done  out  1  one-cycle pulse at completion.
- rdata  out  32  load result (LD/POP), held until next load completes.
- err  out  1  one-cycle pulse with done on timeout (0 without MAU_TIMEOUT_EN).
- sp  out  ADDR_W  current stack pointer.
- mem_req  out  1  bus request.
- mem_we  out  1  1=write.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  write data.
- mem_ack  in  1  memory completion; read data valid in the same cycle.
- mem_rdata  in  32  read data.

Behaviour:
- Reset (rst_n=0 at a clk edge) has priority over everything. Reset values:
  - busy=0, done=0, err=0, mem_req=0, mem_we=0.
  - mem_addr=0, mem_wdata=0, rdata=0, sp=SP_INIT.
  - Reset mid-transaction abandons it; no done pulse. A mem_ack arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT, FIN.
- IDLE:
  - On start=1, latch op, addr[ADDR_W-1:0] and wdata, set busy=1, go to REQ.
  - start while busy=1 is ignored (no queueing).
- REQ: drive mem_req=1, mem_we, mem_addr and mem_wdata; go to WAIT.
- WAIT:
  - mem_req stays 1 and all bus outputs stay stable until mem_ack.
  - On mem_ack: drop mem_req the next cycle. For LD/POP, capture mem_rdata into rdata. Go to FIN.
  - mem_ack in the REQ cycle is also honoured: REQ goes straight to FIN with the same capture.
- FIN: done=1 for one cycle, busy=0, return to IDLE. Minimum latency from start to done is 3 cycles with a zero-wait memory.
- Stack pointer is full-descending:
  - PUSH: address is sp-1; sp is updated to sp-1 at the ack.
  - POP: address is sp; sp is updated to sp+1 at the ack.
  - Arithmetic is modulo 2^ADDR_W; SP_INIT+1 wraps to 0 with no flag.
- addr bits above ADDR_W are ignored. LD/ST never modify sp.
- mem_we=1 for ST/PUSH and 0 for LD/POP; mem_wdata is don't-care (held at the latched value) for reads.

Optional Feature:
- MAU_TIMEOUT_EN defined:
  - An 8+ bit counter (sized for TMO_CYC) runs while mem_req=1.
  - If it reaches TMO_CYC without mem_ack: drop mem_req, go to FIN, pulse done and err together.
  - On timeout, rdata and sp are left unchanged.
- MAU_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely; err is tied to 0.

Decomposition:
- Shared package/header (alongside the existing opcode defines): op encodings MAU_LD/MAU_ST/MAU_PUSH/MAU_POP and the FSM state encodings.
- One natural sub-module, mau_stack_ptr: holds sp and provides pre-decrement/post-increment on an update strobe.
- Everything else stays in the top module.

Test Plan:
- ST op=1, addr=32'h0000_0010, wdata=32'hDEADBEEF, mem_ack one cycle after mem_req → mem_we=1, mem_addr=16'h0010, mem_wdata=DEADBEEF; done exactly 1 cycle after the ack cycle; rdata unchanged.
- LD addr=32'h1234_0020, memory acks after 5 wait cycles with mem_rdata=32'hCAFEF00D → mem_addr=16'h0020, bus held stable for all 5 cycles, rdata=CAFEF00D with done, busy low the same cycle.
- After reset: PUSH 32'h11, then POP → PUSH writes addr 16'hFFFE with sp=16'hFFFE after; POP reads 16'hFFFE, rdata=32'h11, sp=16'hFFFF.
- sp wrap: POP with sp=16'hFFFF → reads 16'hFFFF, sp becomes 16'h0000. Start asserted while busy=1 → ignored, no second transaction.
- Reset asserted in WAIT, then mem_ack delivered → no done, mem_req=0, sp=SP_INIT; next LD behaves normally.
- With MAU_TIMEOUT_EN and TMO_CYC=4, no mem_ack → mem_req drops after 4 cycles, done=1 and err=1 in the same cycle, rdata and sp unchanged.
